// File: rtl/rr_arbiter_16.sv
// rr_arbiter_16: round-robin arbiter sharing one resource among N requesters.
// The winner is the first requesting index at or above the rotating pointer,
// with wrap-around. A grant is held until the owner signals done or, when
// MAX_HOLD is non-zero, until it has been held for MAX_HOLD cycles. After
// every release the arbiter spends at least one cycle idle.
module rr_arbiter_16 #(
  parameter int N        = 16,
  parameter int IDW      = 4,
  parameter int MAX_HOLD = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           grant_valid,
  output logic           timeout
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [15:0]  HOLD_LAST = 16'(MAX_HOLD - 1);
  localparam logic [IDW-1:0] ID_LAST = IDW'(N - 1);
  localparam logic [N-1:0]   ONE_HOT_0 = {{(N-1){1'b0}}, 1'b1};

  // Registered state and outputs
  state_t         r_state;
  logic [IDW-1:0] r_ptr;
  logic [15:0]    r_hold_cnt;
  logic [N-1:0]   r_grant;
  logic [IDW-1:0] r_grant_id;
  logic           r_grant_valid;
  logic           r_timeout;

  // Next-state values
  state_t         w_state_nxt;
  logic [IDW-1:0] w_ptr_nxt;
  logic [15:0]    w_hold_cnt_nxt;
  logic [N-1:0]   w_grant_nxt;
  logic [IDW-1:0] w_grant_id_nxt;
  logic           w_grant_valid_nxt;
  logic           w_timeout_nxt;

  logic [IDW-1:0] w_winner;
  logic [IDW-1:0] w_ptr_after;
  logic           w_hold_expired;

  // Rotating-priority search: first set bit of r starting at p, wrapping.
  function automatic logic [IDW-1:0] f_rr_pick(input logic [N-1:0]   r,
                                               input logic [IDW-1:0] p);
    logic [IDW-1:0] idx;
    logic           found;
    f_rr_pick = p;
    found     = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = IDW'((int'(p) + k) % N);
      if (!found && r[idx]) begin
        f_rr_pick = idx;
        found     = 1'b1;
      end
    end
  endfunction

  assign w_winner       = f_rr_pick(req, r_ptr);
  // The pointer moves just past the requester being released.
  assign w_ptr_after    = (r_grant_id == ID_LAST) ? '0 : r_grant_id + IDW'(1);
  assign w_hold_expired = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST);

  // Next-state and next-output decode for the IDLE/BUSY controller
  always_comb begin
    // NOTE: every target gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    w_state_nxt       = r_state;
    w_ptr_nxt         = r_ptr;
    w_hold_cnt_nxt    = r_hold_cnt;
    w_grant_nxt       = r_grant;
    w_grant_id_nxt    = r_grant_id;
    w_grant_valid_nxt = r_grant_valid;
    w_timeout_nxt     = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_grant_nxt       = '0;
        w_grant_valid_nxt = 1'b0;
        if (enable && (|req)) begin
          w_grant_nxt       = ONE_HOT_0 << w_winner;
          w_grant_id_nxt    = w_winner;
          w_grant_valid_nxt = 1'b1;
          w_hold_cnt_nxt    = '0;
          w_state_nxt       = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // done has priority over a coincident hold expiry
        if (done || w_hold_expired) begin
          w_grant_nxt       = '0;
          w_grant_valid_nxt = 1'b0;
          w_ptr_nxt         = w_ptr_after;
          w_timeout_nxt     = !done;
          w_state_nxt       = ST_IDLE;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + 16'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state       <= ST_IDLE;
      r_ptr         <= '0;
      r_hold_cnt    <= '0;
      r_grant       <= '0;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ptr         <= w_ptr_nxt;
      r_hold_cnt    <= w_hold_cnt_nxt;
      r_grant       <= w_grant_nxt;
      r_grant_id    <= w_grant_id_nxt;
      r_grant_valid <= w_grant_valid_nxt;
      r_timeout     <= w_timeout_nxt;
    end
  end

  assign grant       = r_grant;
  assign grant_id    = r_grant_id;
  assign grant_valid = r_grant_valid;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// tb_rr_arbiter_16: directed scenarios plus randomized traffic for the
// round-robin arbiter, checked cycle by cycle against a behavioural model.
module tb_rr_arbiter_16;

  localparam int N        = 16;
  localparam int IDW      = 4;
  localparam int MAX_HOLD = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic [N-1:0]   req;
  logic           done;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           grant_valid;
  logic           timeout;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: who owns the resource, for how long, where the pointer is
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_held;
  bit m_timeout;

  always #5 clk = ~clk;

  rr_arbiter_16 #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scan requesters in order ptr, ptr+1, ... (mod N); return first requester.
  function automatic int next_served(input int ptr, input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int w;
    m_timeout = 1'b0;
    if (rst) begin
      m_busy  = 1'b0;
      m_owner = 0;
      m_ptr   = 0;
      m_held  = 0;
    end else if (!m_busy) begin
      w = next_served(m_ptr, req);
      if (enable && w >= 0) begin
        m_busy  = 1'b1;
        m_owner = w;
        m_held  = 1;
      end
    end else if (done || (MAX_HOLD != 0 && m_held == MAX_HOLD)) begin
      m_timeout = !done;
      m_busy    = 1'b0;
      m_ptr     = (m_owner + 1) % N;
    end else begin
      m_held++;
    end
  endtask

  // One clock: update the model at the edge, compare all outputs 1 ns later.
  task automatic step();
    logic [31:0] exp_grant;
    @(posedge clk);
    model_edge();
    #1;
    exp_grant = m_busy ? (32'h1 << m_owner) : 32'h0;
    check("grant", 32'(grant), exp_grant);
    check("grant_id", 32'(grant_id), 32'(m_owner));
    check("grant_valid", 32'(grant_valid), 32'(m_busy));
    check("timeout", 32'(timeout), 32'(m_timeout));
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  task automatic release_grant();
    done = 1'b1;
    step();
    done = 1'b0;
  endtask

  int vcnt;

  initial begin
    rst = 1'b1; enable = 1'b0; req = '0; done = 1'b0;
    m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_held = 0; m_timeout = 1'b0;

    // 1: reset with all requests active
    req = 16'hFFFF; enable = 1'b1;
    do_reset(2);
    check("t1_grant", 32'(grant), 32'h0);
    check("t1_gid", 32'(grant_id), 32'h0);
    check("t1_gvld", 32'(grant_valid), 32'h0);
    check("t1_tmo", 32'(timeout), 32'h0);

    // 2: single request, release, then pointer has moved to 1
    req = 16'h0001;
    step();
    check("t2_grant", 32'(grant), 32'h1);
    check("t2_gid", 32'(grant_id), 32'h0);
    release_grant();
    check("t2_rel", 32'(grant_valid), 32'h0);
    req = 16'h0003;
    step();
    check("t2_next", 32'(grant_id), 32'h1);
    release_grant();

    // 3: all requesting, done 3 cycles into each grant -> ids in order
    do_reset(1);
    req = 16'hFFFF;
    for (int j = 0; j < 18; j++) begin
      step();
      check("t3_gid", 32'(grant_id), 32'(j % 16));
      step();
      step();
      check("t3_held", 32'(grant_valid), 32'h1);
      release_grant();
      check("t3_gap", 32'(grant_valid), 32'h0);
    end

    // 4: pointer at 5, requests 0 and 4 -> wrap to 0, then 4
    do_reset(1);
    req = 16'h0010;
    step();
    check("t4_first", 32'(grant_id), 32'h4);
    release_grant();
    req = 16'h0011;
    step();
    check("t4_wrap", 32'(grant_id), 32'h0);
    release_grant();
    step();
    check("t4_after", 32'(grant_id), 32'h4);
    release_grant();

    // 5: hold timeout after MAX_HOLD cycles, ptr moves to 9
    do_reset(1);
    req = 16'h0100;
    vcnt = 0;
    step();
    while (grant_valid && vcnt < 20) begin
      vcnt++;
      step();
    end
    check("t5_hold_len", 32'(vcnt), 32'(MAX_HOLD));
    check("t5_tmo", 32'(timeout), 32'h1);
    req = 16'h0300;
    step();
    check("t5_tmo_clr", 32'(timeout), 32'h0);
    check("t5_ptr9", 32'(grant_id), 32'h9);
    release_grant();
    // done coinciding with the expiry cycle: done wins
    req = 16'h0100;
    step();
    check("t5b_gid", 32'(grant_id), 32'h8);
    step(); step(); step();
    done = 1'b1;
    step();
    done = 1'b0;
    check("t5b_tmo", 32'(timeout), 32'h0);
    check("t5b_rel", 32'(grant_valid), 32'h0);

    // 6: reset mid-grant, then grant from 0; enable low blocks grants
    do_reset(1);
    req = 16'h0080;
    step();
    check("t6_gid7", 32'(grant_id), 32'h7);
    do_reset(1);
    check("t6_rst_grant", 32'(grant), 32'h0);
    check("t6_rst_gid", 32'(grant_id), 32'h0);
    req = 16'hFFFF;
    step();
    check("t6_gid0", 32'(grant_id), 32'h0);
    release_grant();
    enable = 1'b0;
    repeat (4) step();
    check("t6_no_grant", 32'(grant_valid), 32'h0);
    enable = 1'b1;

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 3))
        0:       req = N'($urandom);
        1:       req = N'($urandom) & N'($urandom) & N'($urandom);
        2:       req = N'(1) << $urandom_range(0, N - 1);
        default: req = '0;
      endcase
      enable = ($urandom_range(0, 9) != 0);
      done   = ($urandom_range(0, 3) == 0);
      rst    = ($urandom_range(0, 249) == 0);
      step();
    end
    rst = 1'b0; done = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
